// File: rtl/addb_sched.sv
// ============================================================================
// addb_sched: round-robin scheduler feeding a shared ADPCM reconstruction adder
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module addb_sched #(
  parameter int NCH = 4,
  parameter int CHW = 2
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic [NCH-1:0]    REQ,
  input  logic [16*NCH-1:0] DQ_IN,
  input  logic [15*NCH-1:0] SE_IN,
  output logic [NCH-1:0]    ACK,
  output logic [15:0]       SR,
  output logic [CHW-1:0]    SR_CH,
  output logic              SR_VALID,
  input  logic              SR_READY,
  output logic              PROTO_ERR
);

  logic [CHW-1:0] r_ptr;
  logic [NCH-1:0] r_pending;
  logic [15:0]    r_sr;
  logic [CHW-1:0] r_sr_ch;
  logic           r_sr_valid;
  logic           r_proto_err;

  logic           w_slot_free;
  logic           w_found;
  logic [CHW-1:0] w_grant_idx;
  logic [CHW-1:0] w_idx;
  logic [NCH-1:0] w_ack;
  logic           w_grant;
  logic [15:0]    w_dq;
  logic [14:0]    w_se;
  logic [15:0]    w_dqi;
  logic [15:0]    w_sei;
  logic [15:0]    w_sum;
  logic [NCH-1:0] w_viol;

  assign w_slot_free = !r_sr_valid || SR_READY;

  // Search starts at the pointer; index arithmetic wraps because NCH is a power of two
  always_comb begin
    w_found     = 1'b0;
    w_grant_idx = '0;
    w_idx       = '0;
    for (int k = 0; k < NCH; k++) begin
      w_idx = r_ptr + CHW'(k);
      if (!w_found && REQ[w_idx]) begin
        w_found     = 1'b1;
        w_grant_idx = w_idx;
      end
    end
  end

  always_comb begin
    w_ack = '0;
    if (RST_N && w_slot_free && w_found)
      w_ack = NCH'(1) << w_grant_idx;
  end

  assign w_grant = |w_ack;

  always_comb begin
    w_dq = '0;
    w_se = '0;
    for (int i = 0; i < NCH; i++) begin
      if (w_grant_idx == CHW'(i)) begin
        w_dq = DQ_IN[i*16 +: 16];
        w_se = SE_IN[i*15 +: 15];
      end
    end
  end

  // Sign-magnitude to two's complement; negative zero naturally yields zero
  assign w_dqi = w_dq[15] ? (16'd0 - {1'b0, w_dq[14:0]}) : {1'b0, w_dq[14:0]};
  assign w_sei = {w_se[14], w_se};
  assign w_sum = w_dqi + w_sei;

  // A request that was outstanding and unacknowledged must not be withdrawn
  assign w_viol = r_pending & ~REQ;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_ptr       <= '0;
      r_pending   <= '0;
      r_sr        <= '0;
      r_sr_ch     <= '0;
      r_sr_valid  <= 1'b0;
      r_proto_err <= 1'b0;
    end else begin
      if (w_grant) begin
        r_sr       <= w_sum;
        r_sr_ch    <= w_grant_idx;
        r_sr_valid <= 1'b1;
        r_ptr      <= w_grant_idx + CHW'(1);
      end else if (r_sr_valid && SR_READY) begin
        r_sr_valid <= 1'b0;
      end
      r_pending   <= REQ & ~w_ack;
      r_proto_err <= r_proto_err | (|w_viol);
    end
  end

  assign ACK       = w_ack;
  assign SR        = r_sr;
  assign SR_CH     = r_sr_ch;
  assign SR_VALID  = r_sr_valid;
  assign PROTO_ERR = r_proto_err;

endmodule

`default_nettype wire

// File: tb/tb_addb_sched.sv
// ============================================================================
// tb_addb_sched: table-driven and directed-sequence bench for addb_sched
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_addb_sched;
  localparam int NCH = 4;
  localparam int CHW = 2;

  logic              CLK = 1'b0;
  logic              RST_N;
  logic [NCH-1:0]    REQ;
  logic [16*NCH-1:0] DQ_IN;
  logic [15*NCH-1:0] SE_IN;
  logic [NCH-1:0]    ACK;
  logic [15:0]       SR;
  logic [CHW-1:0]    SR_CH;
  logic              SR_VALID;
  logic              SR_READY;
  logic              PROTO_ERR;

  addb_sched #(.NCH(NCH), .CHW(CHW)) dut (
    .CLK(CLK), .RST_N(RST_N), .REQ(REQ), .DQ_IN(DQ_IN), .SE_IN(SE_IN),
    .ACK(ACK), .SR(SR), .SR_CH(SR_CH), .SR_VALID(SR_VALID),
    .SR_READY(SR_READY), .PROTO_ERR(PROTO_ERR)
  );

  always #5 CLK = ~CLK;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_ops(input int ch, input logic [15:0] dq, input logic [14:0] se);
    DQ_IN[ch*16 +: 16] = dq;
    SE_IN[ch*15 +: 15] = se;
  endtask

  typedef struct {
    int          ch;
    logic [15:0] dq;
    logic [14:0] se;
    logic [15:0] sr;
  } vec_t;

  vec_t vecs[9];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{0, 16'h0005, 15'h0003, 16'h0008};
    vecs[1] = '{1, 16'h8005, 15'h0003, 16'hFFFE};
    vecs[2] = '{2, 16'h0001, 15'h7FFF, 16'h0000};
    vecs[3] = '{3, 16'h8000, 15'h0010, 16'h0010};
    vecs[4] = '{0, 16'h7FFF, 15'h3FFF, 16'hBFFE};
    vecs[5] = '{1, 16'hFFFF, 15'h4000, 16'h4001};
    vecs[6] = '{2, 16'h0000, 15'h0000, 16'h0000};
    vecs[7] = '{3, 16'h8001, 15'h0001, 16'h0000};
    vecs[8] = '{0, 16'h1234, 15'h0100, 16'h1334};

    // Reset state, with requests present to confirm ACK is suppressed
    RST_N    = 1'b0;
    REQ      = '1;
    DQ_IN    = '0;
    SE_IN    = '0;
    SR_READY = 1'b1;
    #2;
    chk("reset_ack",   32'(ACK),       32'h0);
    chk("reset_sr",    32'(SR),        32'h0);
    chk("reset_sr_ch", 32'(SR_CH),     32'h0);
    chk("reset_valid", 32'(SR_VALID),  32'h0);
    chk("reset_perr",  32'(PROTO_ERR), 32'h0);
    REQ = '0;
    @(posedge CLK); #1;
    RST_N = 1'b1;

    // Arithmetic vectors, one channel at a time, back-to-back
    for (int i = 0; i < 9; i++) begin
      REQ = '0;
      REQ[vecs[i].ch] = 1'b1;
      set_ops(vecs[i].ch, vecs[i].dq, vecs[i].se);
      #1;
      chk($sformatf("vec%0d_ack", i), 32'(ACK), 32'(4'b0001 << vecs[i].ch));
      @(posedge CLK); #1;
      REQ = '0;
      chk($sformatf("vec%0d_sr", i),    32'(SR),       32'(vecs[i].sr));
      chk($sformatf("vec%0d_sr_ch", i), 32'(SR_CH),    32'(vecs[i].ch));
      chk($sformatf("vec%0d_valid", i), 32'(SR_VALID), 32'h1);
    end
    chk("table_perr", 32'(PROTO_ERR), 32'h0);

    // Stall: slot full, downstream not ready, ch1 waiting
    SR_READY = 1'b0;
    REQ      = 4'b0010;
    set_ops(1, 16'h0002, 15'h0001);
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("stall%0d_ack", c), 32'(ACK), 32'h0);
      @(posedge CLK); #1;
      chk($sformatf("stall%0d_sr", c),    32'(SR),       32'h1334);
      chk($sformatf("stall%0d_valid", c), 32'(SR_VALID), 32'h1);
    end
    SR_READY = 1'b1;
    #1;
    chk("unstall_ack", 32'(ACK), 32'h2);
    @(posedge CLK); #1;
    REQ = '0;
    chk("unstall_sr",    32'(SR),       32'h0003);
    chk("unstall_sr_ch", 32'(SR_CH),    32'h1);
    chk("unstall_valid", 32'(SR_VALID), 32'h1);

    // Consume with no grant: valid clears, data holds
    @(posedge CLK); #1;
    chk("consume_valid", 32'(SR_VALID),  32'h0);
    chk("consume_sr",    32'(SR),        32'h0003);
    chk("consume_sr_ch", 32'(SR_CH),     32'h1);
    chk("consume_perr",  32'(PROTO_ERR), 32'h0);

    // Protocol violation: fill slot, stall, request ch2 then drop it unacked
    REQ = 4'b0001;
    set_ops(0, 16'h0000, 15'h0000);
    #1;
    chk("pv_fill_ack", 32'(ACK), 32'h1);
    @(posedge CLK); #1;
    SR_READY = 1'b0;
    REQ      = 4'b0100;
    #1;
    chk("pv_req_ack", 32'(ACK), 32'h0);
    @(posedge CLK); #1;
    REQ = '0;
    chk("pv_before_perr", 32'(PROTO_ERR), 32'h0);
    @(posedge CLK); #1;
    chk("pv_set_perr", 32'(PROTO_ERR), 32'h1);
    repeat (10) @(posedge CLK);
    #1;
    chk("pv_sticky_perr", 32'(PROTO_ERR), 32'h1);

    // Asynchronous reset mid-stream, then round-robin over all channels
    SR_READY = 1'b1;
    REQ      = 4'b1111;
    for (int i = 0; i < NCH; i++) set_ops(i, 16'(i + 1), 15'(16 * i));
    @(posedge CLK); #3;
    RST_N = 1'b0;
    #1;
    chk("areset_valid", 32'(SR_VALID),  32'h0);
    chk("areset_perr",  32'(PROTO_ERR), 32'h0);
    chk("areset_ack",   32'(ACK),       32'h0);
    #2;
    RST_N = 1'b1;
    #1;
    for (int k = 0; k < 8; k++) begin
      int e;
      e = k % NCH;
      chk($sformatf("rr%0d_ack", k), 32'(ACK), 32'(4'b0001 << e));
      @(posedge CLK); #1;
      chk($sformatf("rr%0d_sr", k),    32'(SR),       32'(17 * e + 1));
      chk($sformatf("rr%0d_sr_ch", k), 32'(SR_CH),    32'(e));
      chk($sformatf("rr%0d_valid", k), 32'(SR_VALID), 32'h1);
    end
    chk("rr_perr", 32'(PROTO_ERR), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

`default_nettype wire

// File: doc/addb_sched.md
ADDB_SCHED -- requirements
Module: addb_sched

Interface
REQ-001 Parameter NCH, default 4, number of requesting channels (power of two, 2..8).
REQ-002 Parameter CHW, default 2, channel-index width, equal to log2(NCH).
REQ-003 Port CLK  input  1  single clock; all state updates on the rising edge.
REQ-004 Port RST_N  input  1  reset, asynchronous, active-low.
REQ-005 Port REQ  input  NCH  per-channel request; REQ[i] held high with its operands until ACK[i].
REQ-006 Port DQ_IN  input  16*NCH  per-channel quantized difference, sign-magnitude; channel i occupies bits [16i+15:16i], bit 15 is the sign.
REQ-007 Port SE_IN  input  15*NCH  per-channel signal estimate, two's complement; channel i occupies bits [15i+14:15i].
REQ-008 Port ACK  output  NCH  one-hot grant pulse; operands of the granted channel are captured at the edge that ends the ACK cycle.
REQ-009 Port SR  output  16  registered reconstructed signal.
REQ-010 Port SR_CH  output  CHW  channel index of SR.
REQ-011 Port SR_VALID  output  1  SR/SR_CH hold a result not yet consumed.
REQ-012 Port SR_READY  input  1  downstream accepts SR when SR_VALID and SR_READY are both high at an edge.
REQ-013 Port PROTO_ERR  output  1  sticky flag for a requester protocol violation.

Function
REQ-014 Output slot has two states: EMPTY (SR_VALID=0) and FULL (SR_VALID=1).
REQ-015 Slot is free in a cycle when SR_VALID=0, or when SR_VALID=1 and SR_READY=1.
REQ-016 ACK is combinational: all zero when the slot is not free or REQ=0; otherwise exactly one bit is set.
REQ-017 The granted channel is the first i with REQ[i]=1, searching PTR, PTR+1, ... modulo NCH.
REQ-018 On a grant to channel g, PTR becomes (g+1) mod NCH at the edge; otherwise PTR is unchanged.
REQ-019 DQI = {1'b0,DQ[14:0]} when DQ[15]=0; (65536 - DQ[14:0]) mod 65536 when DQ[15]=1; negative zero 0x8000 maps to 0x0000.
REQ-020 SEI = {SE[14],SE}, 16-bit sign extension.
REQ-021 SR = (DQI + SEI) mod 65536, no saturation and no overflow flag.
REQ-022 On a grant, the edge loads SR and SR_CH=g and sets SR_VALID=1; latency from ACK cycle to SR_VALID is one cycle.
REQ-023 Consume without grant (SR_VALID=1, SR_READY=1, REQ=0): SR_VALID clears; SR and SR_CH keep their values.
REQ-024 Simultaneous consume and grant in one cycle: the slot reloads with the new result and SR_VALID stays 1, giving one result per cycle sustained.
REQ-025 FULL with SR_READY=0: SR, SR_CH and SR_VALID hold, and ACK=0.
REQ-026 Protocol violation: REQ[i] was 1 in the previous cycle with ACK[i]=0, and REQ[i] is now 0.
REQ-027 A protocol violation sets PROTO_ERR at the next edge; PROTO_ERR then stays 1 until reset.
REQ-028 A channel whose REQ is low is skipped by arbitration without consuming a cycle; an idle channel costs no bandwidth.

Reset
REQ-029 While RST_N=0, asynchronously: SR=0x0000, SR_CH=0, SR_VALID=0, PTR=0, PROTO_ERR=0, and the previous-REQ register is cleared.
REQ-030 While RST_N=0, ACK=0.
REQ-031 A result in flight when reset asserts is discarded.
REQ-032 The first grant after RST_N rises may occur in the first clock cycle.

Verification
REQ-033 Directed: ch0 DQ=0x0005, SE=0x0003 -> ACK[0]=1, next cycle SR=0x0008, SR_CH=0, SR_VALID=1.
REQ-034 Directed: DQ=0x8005, SE=0x0003 -> SR=0xFFFE.
REQ-035 Directed: DQ=0x0001, SE=0x7FFF -> SR=0x0000.
REQ-036 Directed: DQ=0x8000, SE=0x0010 -> SR=0x0010.
REQ-037 Directed: DQ=0x7FFF, SE=0x3FFF -> SR=0xBFFE (wrap).
REQ-038 Directed: REQ=4'b1111 held, operands re-presented after each ACK, SR_READY=1 -> ACK sequence 0,1,2,3,0,...; SR_VALID continuously 1 after the first cycle.
REQ-039 Directed: FULL, SR_READY=0 for 3 cycles with REQ[1]=1 -> ACK=0 and SR stable; SR_READY=1 -> ACK[1] in that cycle, new SR next cycle.
REQ-040 Directed: REQ[2] high for 1 cycle, dropped while the slot is stalled -> PROTO_ERR=1 next cycle, still 1 after 10 further cycles.
REQ-041 Directed: RST_N pulsed low mid-stream, asynchronous to CLK -> SR_VALID=0 and PROTO_ERR=0 immediately; first grant after release goes to ch0 when REQ=4'b1111.
